// File: rtl/alu_control_sequencer.sv
// Hardwired Moore control unit sequencing fetch and 3-register ALU execute.
// Optional SINGLE_STEP_EN adds a Step input and a PAUSE state after each instruction.
module alu_control_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Run,
    input  logic [31:0]        IR,
    input  logic               MemDone,
`ifdef SINGLE_STEP_EN
    input  logic               Step,
`endif
    output logic               PCout,
    output logic               ZLowout,
    output logic               MDRout,
    output logic               MARin,
    output logic               PCin,
    output logic               MDRin,
    output logic               IRin,
    output logic               Yin,
    output logic               ZLowIn,
    output logic               IncPC,
    output logic               Read,
    output logic               Gra,
    output logic               Grb,
    output logic               Grc,
    output logic               Rin,
    output logic               Rout,
    output logic [4:0]         AluOp,
    output logic               Halted,
    output logic               Fault,
    output logic [COUNT_W-1:0] InstrCount
);

    localparam logic [7:0] LP_TMO = 8'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
`ifdef SINGLE_STEP_EN
        S_PAUSE,
`endif
        S_HALT,
        S_FAULT
    } state_t;

    state_t             r_state;
    logic [7:0]         r_wait;
    logic [COUNT_W-1:0] r_count;
`ifdef SINGLE_STEP_EN
    logic               r_armed;
`endif

    logic [4:0] w_op;
    logic       w_alu;
    logic       w_first_t1;
    logic       w_unused;

    assign w_op       = IR[31:27];
    assign w_alu      = (w_op[4:3] == 2'b00);
    assign w_first_t1 = (r_wait == 8'd0);
    assign w_unused   = ^IR[26:0];
    assign InstrCount = r_count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_wait  <= 8'd0;
            r_count <= '0;
`ifdef SINGLE_STEP_EN
            r_armed <= 1'b1;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: if (Run) r_state <= S_T0;
                S_T0: begin
                    r_state <= S_T1;
                    r_wait  <= 8'd0;
                end
                S_T1: begin
                    if (MemDone) begin
                        r_state <= S_T2;
                    end else if (r_wait + 8'd1 >= LP_TMO) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_T2: r_state <= S_T3;
                S_T3: begin
                    if (w_alu)              r_state <= S_T4;
                    else if (&w_op)         r_state <= S_HALT;
                    else                    r_state <= S_FAULT;
                end
                S_T4: r_state <= S_T5;
                S_T5: begin
                    r_count <= r_count + 1'b1;
`ifdef SINGLE_STEP_EN
                    r_state <= Run ? S_PAUSE : S_IDLE;
`else
                    r_state <= Run ? S_T0 : S_IDLE;
`endif
                end
`ifdef SINGLE_STEP_EN
                // One instruction per Step pulse; Step must drop before re-arming
                S_PAUSE: begin
                    if (!Step) r_armed <= 1'b1;
                    if (!Run) begin
                        r_state <= S_IDLE;
                    end else if (Step && r_armed) begin
                        r_state <= S_T0;
                        r_armed <= 1'b0;
                    end
                end
`endif
                S_HALT:  r_state <= S_HALT;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PCout   = 1'b0;
        ZLowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        ZLowIn  = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        AluOp   = 5'd0;
        Halted  = 1'b0;
        Fault   = 1'b0;
        unique case (r_state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            S_T1: begin
                ZLowout = w_first_t1;
                PCin    = w_first_t1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            // IR is valid here; halt/illegal opcodes get no enables
            S_T3: begin
                Grb  = w_alu;
                Rout = w_alu;
                Yin  = w_alu;
            end
            S_T4: begin
                Grc    = 1'b1;
                Rout   = 1'b1;
                ZLowIn = 1'b1;
                AluOp  = w_op;
            end
            S_T5: begin
                ZLowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
            end
            S_HALT:  Halted = 1'b1;
            S_FAULT: Fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed self-checking bench for alu_control_sequencer (COUNT_W=4).
// Covers fetch/execute, memory wait, timeout, halt, illegal opcode, wrap, reset.
module tb_alu_control_sequencer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Run;
    logic [31:0] IR;
    logic       MemDone;
`ifdef SINGLE_STEP_EN
    logic       Step;
`endif
    logic PCout, ZLowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn;
    logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, Halted, Fault;
    logic [4:0] AluOp;
    logic [3:0] InstrCount;
    logic [17:0] w_vec;

    int total = 0;
    int bad   = 0;

    // bus drivers | loads MAR,PC,MDR,IR,Y,Z | IncPC,Read | Ga,Gb,Gc | Rin,Rout | H,F
    localparam logic [17:0] E_IDLE  = 18'b000_000000_00_000_00_00;
    localparam logic [17:0] E_T0    = 18'b100_100001_10_000_00_00;
    localparam logic [17:0] E_T1F   = 18'b010_011000_01_000_00_00;
    localparam logic [17:0] E_T1N   = 18'b000_001000_01_000_00_00;
    localparam logic [17:0] E_T2    = 18'b001_000100_00_000_00_00;
    localparam logic [17:0] E_T3    = 18'b000_000010_00_010_01_00;
    localparam logic [17:0] E_T4    = 18'b000_000001_00_001_01_00;
    localparam logic [17:0] E_T5    = 18'b010_000000_00_100_10_00;
    localparam logic [17:0] E_HALT  = 18'b000_000000_00_000_00_10;
    localparam logic [17:0] E_FAULT = 18'b000_000000_00_000_00_01;

    localparam logic [31:0] IR_OR  = 32'h1891_8000;
    localparam logic [31:0] IR_HLT = 32'hF800_0000;
    localparam logic [31:0] IR_BAD = 32'h6000_0000;

    assign w_vec = {PCout, ZLowout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                    ZLowIn, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Halted, Fault};

    alu_control_sequencer #(.MEM_TIMEOUT(15), .COUNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .MemDone(MemDone),
`ifdef SINGLE_STEP_EN
        .Step(Step),
`endif
        .PCout(PCout), .ZLowout(ZLowout), .MDRout(MDRout), .MARin(MARin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
        .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .AluOp(AluOp), .Halted(Halted),
        .Fault(Fault), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [17:0] exp,
                       input logic [4:0] alu);
        total++;
        assert (w_vec === exp) else begin
            bad++;
            $error("FAIL %s ctrl got %b want %b", tag, w_vec, exp);
        end
        total++;
        assert (AluOp === alu) else begin
            bad++;
            $error("FAIL %s aluop got %0d want %0d", tag, AluOp, alu);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] exp);
        total++;
        assert (InstrCount === exp) else begin
            bad++;
            $error("FAIL %s count got %0d want %0d", tag, InstrCount, exp);
        end
    endtask

    // Entered in T0; leaves after the T5 edge
    task automatic run_instr(input string tag, input logic [31:0] ir,
                             input logic [4:0] op);
        IR = ir;
        chk({tag, "_t0"}, E_T0, 5'd0);
        tick();
        chk({tag, "_t1"}, E_T1F, 5'd0);
        tick();
        chk({tag, "_t2"}, E_T2, 5'd0);
        tick();
        chk({tag, "_t3"}, E_T3, 5'd0);
        tick();
        chk({tag, "_t4"}, E_T4, op);
        tick();
        chk({tag, "_t5"}, E_T5, 5'd0);
        tick();
    endtask

    initial begin
        Reset   = 1'b1;
        Run     = 1'b1;
        MemDone = 1'b1;
        IR      = IR_OR;
`ifdef SINGLE_STEP_EN
        Step    = 1'b0;
`endif
        repeat (3) begin
            tick();
            chk("reset", E_IDLE, 5'd0);
            chk_cnt("reset_cnt", 4'd0);
        end
        Reset = 1'b0;
        tick();
        run_instr("i1", IR_OR, 5'd3);
        chk_cnt("i1_cnt", 4'd1);

        // MemDone low for 4 T1 cycles
        chk("w_t0", E_T0, 5'd0);
        MemDone = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) MemDone = 1'b1;
            chk(i == 0 ? "w_t1f" : "w_t1n", i == 0 ? E_T1F : E_T1N, 5'd0);
            tick();
        end
        chk("w_t2", E_T2, 5'd0);
        tick();
        chk("w_t3", E_T3, 5'd0);
        tick();
        chk("w_t4", E_T4, 5'd3);
        tick();
        chk("w_t5", E_T5, 5'd0);
        tick();
        chk_cnt("w_cnt", 4'd2);

        // Back-to-back to wrap the 4-bit counter
        for (int k = 3; k <= 16; k++) begin
            run_instr("bb", IR_OR, 5'd3);
            if (k >= 15) chk_cnt("wrap_cnt", 4'(k));
        end

        // Reset during T4
        repeat (4) tick();
        chk("r_t4", E_T4, 5'd3);
        Reset = 1'b1;
        tick();
        chk("r_idle", E_IDLE, 5'd0);
        chk_cnt("r_cnt", 4'd0);
        Reset = 1'b0;
        Run   = 1'b0;
        tick();
        chk("r_stay", E_IDLE, 5'd0);

        // Memory timeout
        Run     = 1'b1;
        MemDone = 1'b0;
        tick();
        chk("to_t0", E_T0, 5'd0);
        tick();
        for (int i = 0; i < 15; i++) begin
            chk(i == 0 ? "to_t1f" : "to_t1n", i == 0 ? E_T1F : E_T1N, 5'd0);
            tick();
        end
        chk("to_fault", E_FAULT, 5'd0);
        repeat (4) begin
            Run = ~Run;
            tick();
            chk("to_sticky", E_FAULT, 5'd0);
        end
        Reset = 1'b1;
        Run   = 1'b1;
        tick();
        chk("to_reset", E_IDLE, 5'd0);

        // Halt opcode
        Reset   = 1'b0;
        MemDone = 1'b1;
        IR      = IR_HLT;
        tick();
        chk("h_t0", E_T0, 5'd0);
        repeat (3) tick();
        chk("h_t3", E_IDLE, 5'd0);
        tick();
        chk("h_halt", E_HALT, 5'd0);
        repeat (3) begin
            Run = ~Run;
            tick();
            chk("h_sticky", E_HALT, 5'd0);
        end
        chk_cnt("h_cnt", 4'd0);

        // Illegal opcode after one good instruction
        Reset = 1'b1;
        Run   = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        run_instr("f0", IR_OR, 5'd3);
        IR = IR_BAD;
        chk("f_t0", E_T0, 5'd0);
        repeat (3) tick();
        chk("f_t3", E_IDLE, 5'd0);
        tick();
        chk("f_fault", E_FAULT, 5'd0);
        chk_cnt("f_cnt", 4'd1);

`ifdef SINGLE_STEP_EN
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        run_instr("s0", IR_OR, 5'd3);
        chk("s_pause", E_IDLE, 5'd0);
        Step = 1'b1;
        tick();
        run_instr("s1", IR_OR, 5'd3);
        repeat (2) begin
            chk("s_hold", E_IDLE, 5'd0);
            tick();
        end
        chk_cnt("s_cnt", 4'd2);
        Step = 1'b0;
        tick();
        chk("s_rearm", E_IDLE, 5'd0);
        Step = 1'b1;
        tick();
        chk("s_go", E_T0, 5'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
